// File: rtl/seq_arb_pkg.sv
// rtl/seq_arb_pkg.sv - shared types and index/one-hot helpers for the sequence-number table arbiter
package seq_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Helpers work at a fixed maximum width; callers cast to their own width.
    localparam int MAX_REQ   = 64;
    localparam int MAX_IDX_W = 6;

    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int b = 0; b < MAX_IDX_W; b++) begin
            for (int i = 0; i < MAX_REQ; i++) begin
                if (((i >> b) & 1) != 0) begin
                    idx[b] = idx[b] | oh[i];
                end
            end
        end
        return idx;
    endfunction

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/seq_num_table_arbiter_rr_grant_picker.sv
// rtl/seq_num_table_arbiter_rr_grant_picker.sv - combinational round-robin pick starting at ptr
module rr_grant_picker #(
    parameter int NUM_REQ = 8,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               any_valid
);

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] first;
    logic [IDX_W-1:0]   back_ptr;

    assign cand      = req & ~mask;
    assign any_valid = |cand;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back by -ptr.
    assign rot      = NUM_REQ'({cand, cand} >> ptr);
    assign first    = rot & (~rot + NUM_REQ'(1));
    assign back_ptr = IDX_W'(0) - ptr;
    assign winner   = NUM_REQ'({first, first} >> back_ptr);

endmodule

// File: rtl/seq_num_table_arbiter.sv
// rtl/seq_num_table_arbiter.sv - round-robin owner arbiter for the table port; SEQ_ARB_TIMEOUT_EN adds the hold limit
module seq_num_table_arbiter
    import seq_arb_pkg::*;
#(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 16,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_done,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_grant_valid,
    output logic               o_timeout
);

    arb_state_t         state;
    arb_state_t         state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_mask;
    logic [NUM_REQ-1:0] winner;
    logic [NUM_REQ-1:0] grant_next;
    logic               any_valid;
    logic               hold_hit;
    logic               release_now;
    logic               new_grant;

    // While busy, re-arbitrate with the owner masked and the pointer already advanced past it.
    assign pick_ptr  = (state == BUSY) ? o_grant_idx + IDX_W'(1) : ptr;
    assign pick_mask = (state == BUSY) ? NUM_REQ'(idx_to_onehot(MAX_IDX_W'(o_grant_idx))) : '0;

    rr_grant_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req       (i_req),
        .mask      (pick_mask),
        .ptr       (pick_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign release_now = (state == BUSY) &&
                         (i_done[o_grant_idx] || !i_req[o_grant_idx] || hold_hit);
    assign new_grant   = any_valid && ((state == IDLE) || release_now);

`ifdef SEQ_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold;

    assign hold_hit  = (state == BUSY) && (hold == HOLD_W'(MAX_HOLD - 1));
    assign o_timeout = hold_hit && !i_done[o_grant_idx];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold <= '0;
        end else if (new_grant) begin
            hold <= '0;
        end else if ((state == BUSY) && (hold != '1)) begin
            hold <= hold + HOLD_W'(1);
        end
    end
`else
    assign hold_hit  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = BUSY;
            BUSY:    if (release_now && !any_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_next = o_grant;
        if (new_grant) begin
            grant_next = winner;
        end else if (release_now) begin
            grant_next = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_grant     <= '0;
            o_grant_idx <= '0;
            ptr         <= '0;
        end else begin
            o_grant     <= grant_next;
            o_grant_idx <= IDX_W'(onehot_to_idx(MAX_REQ'(grant_next)));
            if (release_now) begin
                ptr <= o_grant_idx + IDX_W'(1);
            end
        end
    end

    assign o_grant_valid = |o_grant;

endmodule

// File: tb/tb_seq_num_table_arbiter.sv
// tb/tb_seq_num_table_arbiter.sv - directed and random checks of seq_num_table_arbiter against a behavioural model
module tb_seq_num_table_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 16;
`ifdef SEQ_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    logic [2:0]   grant_idx;
    logic         grant_valid;
    logic         timeout;

    int total = 0;
    int bad   = 0;
    int to_seen;

    int m_owner;
    int m_ptr;
    int m_hold;

    seq_num_table_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_done        (done),
        .o_grant       (grant),
        .o_grant_idx   (grant_idx),
        .o_grant_valid (grant_valid),
        .o_timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int skip, input int start);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (start + i) % N;
            if (r[j] && j != skip) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    // Check outputs for the current cycle, then advance the model across one clock edge.
    task automatic cycle();
        logic [31:0] exp_grant;
        logic        exp_to;
        logic        hit;
        logic        rel;
        int          k;
        #1;
        exp_grant = (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
        check("grant", 32'(grant), exp_grant);
        check("grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("grant_valid", 32'(grant_valid), (m_owner < 0) ? 32'd0 : 32'd1);
        check("onehot", 32'($onehot0(grant)), 32'd1);
        exp_to = 1'b0;
        if (m_owner < 0) begin
            k = pick(req, -1, m_ptr);
            if (k >= 0) begin
                m_owner = k;
                m_hold  = 0;
            end
        end else begin
            k      = m_owner;
            hit    = TO_EN && (m_hold == MAX_HOLD - 1);
            exp_to = hit && !done[k];
            rel    = done[k] || !req[k] || hit;
            if (rel) begin
                m_ptr   = (k + 1) % N;
                m_owner = pick(req, k, m_ptr);
                m_hold  = 0;
            end else if (m_hold < 15) begin
                m_hold = m_hold + 1;
            end
        end
        check("timeout", 32'(timeout), 32'(exp_to));
        to_seen += int'(timeout);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_idx;
        rst  = 1'b1;
        req  = '0;
        done = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_valid", 32'(grant_valid), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;

        // Single requester 2: grant after one cycle, release via done four cycles in.
        req = 8'h04;
        cycle();
        check("t1_grant", 32'(grant), 32'h04);
        check("t1_idx", 32'(grant_idx), 32'd2);
        cycle(); cycle(); cycle();
        done = 8'h04;
        cycle();
        done = '0;
        req  = '0;
        check("t1_release", 32'(grant), 32'd0);
        cycle();

        // All requesting from ptr=3: strict rotation with no idle gap.
        req = 8'hFF;
        cycle();
        for (int n = 0; n < N; n++) begin
            exp_idx = (3 + n) % N;
            check("t2_order", 32'(grant_idx), 32'(exp_idx));
            cycle();
            cycle();
            done = 8'(1 << exp_idx);
            cycle();
            done = '0;
        end
        req = '0;
        cycle();
        cycle();

        // Owner 5 drops its request; a stray done from 6 must not matter.
        req = 8'h20;
        cycle();
        req = 8'h22;
        cycle();
        req  = 8'h02;
        done = 8'h40;
        cycle();
        done = '0;
        check("t3_grant", 32'(grant), 32'h02);
        check("t3_idx", 32'(grant_idx), 32'd1);
        req = '0;
        cycle();
        cycle();

        // Lone requester 0 held with no done: hold limit behaviour.
        to_seen = 0;
        req = 8'h01;
        for (int c = 0; c < 18; c++) cycle();
        check("t4_timeouts", 32'(to_seen), TO_EN ? 32'd1 : 32'd0);
        check("t4_grant", 32'(grant), 32'h01);

        // Hand off to 6, then reset mid-transaction.
        req = 8'h40;
        cycle();
        cycle();
        check("t5_owner6", 32'(grant_idx), 32'd6);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_grant", 32'(grant), 32'd0);
        check("t5_async_valid", 32'(grant_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 8'h41;
        cycle();
        check("t5_after_reset", 32'(grant_idx), 32'd0);
        req = '0;
        cycle();
        cycle();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) req = req ^ 8'(1 << $urandom_range(0, N - 1));
            if ($urandom_range(0, 2) == 0) done = 8'(1 << $urandom_range(0, N - 1));
            else                           done = '0;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
